serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Uses a single 1-bit full-adder cell and a registered carry.
- Start/done handshake.
- Next-generation arithmetic block in the lab adder family: trades latency for a one-cell datapath. Sits behind any register-loaded operand source.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result, held until next done
- cout  output  1  registered final carry, held until next done

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst sampled on rising edge of clk only).
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry reg=0, operand and shift regs=0.
- FSM states:
  - IDLE: start=1 at edge E0 → load a, b into shift regs, carry reg←cin, counter←0, go to RUN. start=0 → stay.
  - RUN: each edge computes s_i = a_i ^ b_i ^ c and c' = majority(a_i, b_i, c) on current LSBs via the full-adder cell. Then:
    - shift operand regs right by 1;
    - shift s_i into the MSB of the internal result reg (right shift);
    - carry reg←c';
    - counter+1.
    - When counter==WIDTH-1 at the edge, the last bit is processed, sum←final result reg, cout←c', go to DONE.
  - DONE: done=1 for exactly this cycle; next edge → IDLE.
- Latency: start accepted at E0; done high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accepting edge. Throughput: one addition per WIDTH+2 cycles when start is held high.
- busy=1 in RUN and DONE; combinational decode of state.
- start in RUN or DONE is ignored; operands are not resampled.
- Changes to a, b or cin after E0 have no effect on the result in flight.
- sum and cout change only on the edge entering DONE (or on reset). Between operations they hold the last result.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag; signed interpretation is left to the user.
- Counter width: $clog2(WIDTH). Counter does not wrap during RUN. It is cleared on entry to RUN.
- Reset mid-operation (RUN or DONE): next cycle is IDLE with all reset values. sum and cout return to 0. The partial result is discarded and done is not asserted.
- rst and start high together: rst wins.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit);
  - localparam function for counter width;
  - WIDTH range check constant used by an elaboration-time assertion.
- Sub-module full_adder_cell: purely combinational, inputs a, b, ci; outputs s, co. Instantiated once in the RUN datapath.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, after reset: check busy=0, done=0, sum=0x00, cout=0. Then start with a=0x00, b=0x00, cin=0 → done exactly 8 cycles after the start edge, sum=0x00, cout=0.
- WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 → sum=0x7E, cout=0. Results hold between done pulses.
- WIDTH=8: start held high for 30 cycles with operands changing every cycle → results use only the operands at each accepting edge. done pulses at 10-cycle spacing. busy never drops between back-to-back operations except the single IDLE cycle.
- WIDTH=8: assert rst for one cycle 4 cycles into RUN → next cycle busy=0, sum=0, cout=0, and no done pulse. A following start with a=0x10, b=0x20 → sum=0x30.
- WIDTH=2: exhaustive loop over all 32 combinations of a, b, cin → {cout,sum}==a+b+cin each time, done 2 cycles after each start.
- WIDTH=64: a=all ones, b=0, cin=1 → sum=0, cout=1, done 64 cycles after start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic cell in the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles from accepted start to done.
// Operands are captured on the accepting edge; sum/cout hold until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam bit WIDTH_LEGAL = width_ok(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (!WIDTH_LEGAL) begin : g_bad_width
            $error("serial_adder: WIDTH out of range 2..64");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_co;
    logic             last_bit;

    full_adder_cell u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    // res keeps only the bits produced so far; the freshly computed bit
    // completes the word on the final step.
    assign res_nxt  = {bit_s, res};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= res_nxt[WIDTH-1:1];
                    carry <= bit_co;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= res_nxt;
                        cout <= bit_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 64 against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       st8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       st2, c2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic        st64, c64, busy64, done64, cout64;
    logic [63:0] a64, b64, sum64;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(c2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );
    serial_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .start(st64), .a(a64), .b(b64), .cin(c64),
        .busy(busy64), .done(done64), .sum(sum64), .cout(cout64)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [64:0] res_of(input int w);
        case (w)
            8:       return 65'({cout8, sum8});
            2:       return 65'({cout2, sum2});
            default: return {cout64, sum64};
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            8:       return done8;
            2:       return done2;
            default: return done64;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            8:       return busy8;
            2:       return busy2;
            default: return busy64;
        endcase
    endfunction

    function automatic logic [64:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return 65'(a & mask) + 65'(b & mask) + 65'(c);
    endfunction

    task automatic drive(input int w, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic c);
        case (w)
            8:       begin st8 = s;  a8 = a[7:0]; b8 = b[7:0]; c8 = c; end
            2:       begin st2 = s;  a2 = a[1:0]; b2 = b[1:0]; c2 = c; end
            default: begin st64 = s; a64 = a;     b64 = b;     c64 = c; end
        endcase
    endtask

    // One operation from an IDLE instance; returns at the negedge inside the done cycle.
    task automatic op(input int w, input logic [63:0] a, input logic [63:0] b,
                      input logic c, output logic [64:0] r, output int lat);
        @(negedge clk);
        drive(w, 1'b1, a, b, c);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, ~a, ~b, ~c);
        chk("busy_after_accept", 65'(busy_of(w)), 65'd1);
        lat = 0;
        while (!done_of(w) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = res_of(w);
    endtask

    logic [64:0] r;
    int          lat;
    int          ndone;
    logic [7:0]  qa[30];
    logic [7:0]  qb[30];
    logic        qc[30];

    initial begin
        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};

        rst = 1'b1;
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(2, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(64, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 65'(busy8), 65'd0);
        chk("reset_done", 65'(done8), 65'd0);
        chk("reset_result", res_of(8), 65'd0);

        for (int i = 0; i < 4; i++) begin
            op(8, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].cin, r, lat);
            chk("tbl_latency", 65'(lat), 65'd8);
            chk("tbl_result", r, 65'({tbl[i].cout, tbl[i].sum}));
            repeat (3) @(negedge clk);
            chk("tbl_hold_done", 65'(done8), 65'd0);
            chk("tbl_hold_result", res_of(8), 65'({tbl[i].cout, tbl[i].sum}));
        end

        for (int i = 0; i < 20; i++) begin
            logic [63:0] ra, rb;
            logic        rc;
            ra = 64'($urandom_range(255));
            rb = 64'($urandom_range(255));
            rc = 1'($urandom_range(1));
            op(8, ra, rb, rc, r, lat);
            chk("rand8_latency", 65'(lat), 65'd8);
            chk("rand8_result", r, model(8, ra, rb, rc));
        end

        // start held high: accepts every WIDTH+2 cycles, operands sampled only at accepting edges
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            qa[k] = 8'($urandom);
            qb[k] = 8'($urandom);
            qc[k] = 1'($urandom);
            drive(8, 1'b1, 64'(qa[k]), 64'(qb[k]), qc[k]);
            @(posedge clk);
            @(negedge clk);
            chk("b2b_done", 65'(done8), 65'(k % 10 == 8));
            chk("b2b_busy", 65'(busy8), 65'(k % 10 != 9));
            if (k % 10 == 8)
                chk("b2b_result", res_of(8), model(8, 64'(qa[k-8]), 64'(qb[k-8]), qc[k-8]));
        end
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);

        op(8, 64'h55, 64'h55, 1'b0, r, lat);
        chk("pre_reset_result", r, 65'h0AA);
        @(negedge clk);
        drive(8, 1'b1, 64'h11, 64'h22, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 64'h0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 65'(busy8), 65'd0);
        chk("midrst_result", res_of(8), 65'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("midrst_no_done", 65'(ndone), 65'd0);
        op(8, 64'h10, 64'h20, 1'b0, r, lat);
        chk("post_reset_result", r, 65'h030);

        for (int v = 0; v < 32; v++) begin
            logic [63:0] ea, eb;
            logic        ec;
            ea = 64'(v[4:3]);
            eb = 64'(v[2:1]);
            ec = v[0];
            op(2, ea, eb, ec, r, lat);
            chk("w2_latency", 65'(lat), 65'd2);
            chk("w2_result", r, model(2, ea, eb, ec));
        end

        op(64, '1, 64'd0, 1'b1, r, lat);
        chk("w64_latency", 65'(lat), 65'd64);
        chk("w64_result", r, {1'b1, 64'd0});
        for (int i = 0; i < 4; i++) begin
            logic [63:0] ra, rb;
            logic        rc;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(1));
            op(64, ra, rb, rc, r, lat);
            chk("w64_rand_result", r, model(64, ra, rb, rc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
